incr_share_arb: RTL and testbench
=================================

// Module: incr_share_arb
// PURPOSE
//  Round-robin arbiter that shares one WIDTH-bit incrementer (z = x + 1) among NREQ requesters.
//  Each requester offers an operand with a valid/ready handshake. The granted operand is incremented
//  and captured in a one-entry output register, tagged with the requester id.
//  Sits between the PD-stage requesters (PC/counter users) and the shared increment datapath.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  4  operand/result width in bits
// PORTS
//  clock      in   1             single clock, rising edge
//  reset_n    in   1             asynchronous, active-low reset
//  req_valid  in   NREQ          requester i offers an operand
//  req_data   in   NREQ*WIDTH    operand of requester i in bits [i*WIDTH +: WIDTH]
//  req_ready  out  NREQ          one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
//  rsp_valid  out  1             result register holds a valid result
//  rsp_id     out  $clog2(NREQ)  index of the requester that produced the result
//  rsp_data   out  WIDTH         req_data + 1
//  rsp_ready  in   1             consumer accepts the result when rsp_valid & rsp_ready
// BEHAVIOUR
//  - Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0. req_ready=0 while reset_n=0.
//  - Output register FSM, two states:
//    - EMPTY (rsp_valid=0).
//    - FULL (rsp_valid=1).
//    - Transitions:
//      - EMPTY->FULL on grant.
//      - FULL->EMPTY on rsp_ready with no grant.
//      - FULL->FULL on a stall, or on rsp_ready with a new grant.
//  - can_accept = !rsp_valid | rsp_ready. req_ready is combinational from req_valid, rr_ptr and can_accept.
//  - Grant rule: if can_accept, grant the first i with req_valid[i]=1, scanning from rr_ptr upward modulo NREQ.
//    At most one req_ready bit is high. req_ready is 0 when can_accept=0 or no request is valid.
//  - On the grant edge:
//    - rsp_data <= req_data[g] + 1, with the sum truncated to WIDTH bits.
//    - rsp_id <= g; rsp_valid <= 1.
//    - rr_ptr <= (g+1) mod NREQ.
//  - rr_ptr changes only on a grant. A requester that drops req_valid before being granted loses nothing.
//  - Latency 1 cycle from accept to rsp_valid. Throughput 1 result per cycle while rsp_ready=1.
//  - Stall (rsp_valid=1, rsp_ready=0): rsp_* held stable, no grants issued.
//  - Simultaneous rsp_ready and a new grant in FULL: the old result retires, the new one loads on the same edge.
//  - Wrap: without the optional feature, operand all-ones -> result 0.
//  - Reset mid-operation: a pending result is discarded and arbitration restarts at requester 0.
// CONFIGURATION
//  - Macro INCR_SHARE_ARB_SAT_EN.
//  - Defined:
//    - Adds output port rsp_sat (1 bit, reset 0).
//    - Operand all-ones -> rsp_data = all-ones (saturates) and rsp_sat=1.
//    - Otherwise rsp_sat=0. rsp_sat is registered alongside rsp_data.
//  - Undefined: no rsp_sat port; result wraps modulo 2^WIDTH.
// STRUCTURE
//  - Package incr_share_pkg:
//    - state typedef {ST_EMPTY, ST_FULL}.
//    - localparam ID_W = $clog2(NREQ) helper.
//    - default NREQ/WIDTH constants.
//  - Sub-module incr_unit (combinational, parameter WIDTH): x -> z = x + 1, plus sat variant under the macro.
//    - Instanced once, fed by the mux of the granted operand.
//  - Round-robin priority scan and output register live in incr_share_arb.
// TESTING
//  - Reset: assert reset_n=0 mid-transfer -> rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0 immediately.
//  - Single request: req_valid=4'b0100, data2=4'h3, rsp_ready=1.
//    -> req_ready=4'b0100; next cycle rsp_valid=1, rsp_id=2, rsp_data=4'h4.
//  - Fairness: all four valid for 8 cycles, rsp_ready=1 -> grants 0,1,2,3,0,1,2,3; one result per cycle.
//  - Backpressure: rsp_ready=0 with rsp_valid=1 for 3 cycles -> req_ready=0, rsp_* stable.
//    Then rsp_ready=1 with req_valid[1] -> retire and new grant on the same edge.
//  - Wrap/sat: operand 4'hF -> rsp_data=4'h0 (macro off); 4'hF with rsp_sat=1 (INCR_SHARE_ARB_SAT_EN on).
//  - Pointer hold: only req 3 requests, then reqs 0 and 3 together -> next grant goes to 0 (rr_ptr=0 after 3).

Source files
------------

// File: rtl/incr_share_pkg.sv
// incr_share_pkg: shared types and defaults for the shared-incrementer arbiter.
// Output-register state encoding and id-width helper.
package incr_share_pkg;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 4;
   localparam int ID_W      = $clog2(NREQ_DEF);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic int id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/incr_unit.sv
// incr_unit: combinational z = x + 1 shared by all requesters.
// With INCR_SHARE_ARB_SAT_EN the all-ones operand saturates and flags sat.
module incr_unit #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] z
`ifdef INCR_SHARE_ARB_SAT_EN
   ,
   output logic             sat
`endif
);

`ifdef INCR_SHARE_ARB_SAT_EN
   // saturating increment: all-ones stays all-ones
   always_comb begin
      sat = &x;
      z   = sat ? x : x + 1'b1;
   end
`else
   // wrapping increment modulo 2^WIDTH
   always_comb begin
      z = x + 1'b1;
   end
`endif

endmodule

// File: rtl/incr_share_arb.sv
// incr_share_arb: round-robin arbiter sharing one incrementer among NREQ requesters.
// Optional macro INCR_SHARE_ARB_SAT_EN adds saturation and the rsp_sat port.
module incr_share_arb
   import incr_share_pkg::*;
#(
   parameter  int NREQ  = NREQ_DEF,
   parameter  int WIDTH = WIDTH_DEF,
   localparam int IW    = id_w(NREQ)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   output logic [IW-1:0]         rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
`ifdef INCR_SHARE_ARB_SAT_EN
   output logic                  rsp_sat,
`endif
   input  logic                  rsp_ready
);

   localparam int SW = IW + 1;

   state_t           state;
   state_t           state_nxt;
   logic             can_accept;
   logic             found;
   logic             fire;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    gnt_id;
   logic [IW-1:0]    ptr_nxt;
   logic [NREQ-1:0]  grant;
   logic [WIDTH-1:0] op;
   logic [WIDTH-1:0] sum;
`ifdef INCR_SHARE_ARB_SAT_EN
   logic             sat_w;
`endif

   assign can_accept = !rsp_valid || rsp_ready;

   // first valid requester at or after rr_ptr, wrapping modulo NREQ
   always_comb begin
      logic [SW-1:0] s;
      logic [IW-1:0] idx;
      s      = '0;
      idx    = '0;
      found  = 1'b0;
      gnt_id = '0;
      for (int k = 0; k < NREQ; k++) begin
         s = {1'b0, rr_ptr} + SW'(k);
         if (s >= SW'(NREQ)) begin
            s = s - SW'(NREQ);
         end
         idx = s[IW-1:0];
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            gnt_id = idx;
         end
      end
   end

   // one-hot grant, suppressed under reset or when the result slot is busy
   always_comb begin
      grant = '0;
      if (reset_n && can_accept && found) begin
         grant[gnt_id] = 1'b1;
      end
   end

   assign req_ready = grant;
   assign fire      = |grant;

   // select the granted operand for the shared incrementer
   always_comb begin
      op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_id == IW'(i)) begin
            op = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   incr_unit #(
      .WIDTH (WIDTH)
   ) u_incr (
      .x   (op),
      .z   (sum)
`ifdef INCR_SHARE_ARB_SAT_EN
      ,
      .sat (sat_w)
`endif
   );

   assign ptr_nxt = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

   // output-register state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // fill on grant, drain on retire without a refill
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_EMPTY: begin
            if (fire) begin
               state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (!fire && rsp_ready) begin
               state_nxt = ST_EMPTY;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // valid flag decoded from state
   always_comb begin
      rsp_valid = (state == ST_FULL);
   end

   // result payload and round-robin pointer advance only on a grant
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_data <= '0;
         rsp_id   <= '0;
         rr_ptr   <= '0;
`ifdef INCR_SHARE_ARB_SAT_EN
         rsp_sat  <= 1'b0;
`endif
      end else if (fire) begin
         rsp_data <= sum;
         rsp_id   <= gnt_id;
         rr_ptr   <= ptr_nxt;
`ifdef INCR_SHARE_ARB_SAT_EN
         rsp_sat  <= sat_w;
`endif
      end
   end

endmodule

// File: tb/tb_incr_share_arb.sv
// tb_incr_share_arb: vector table plus scoreboard for incr_share_arb.
// Covers reset, single grant, fairness, backpressure, wrap/sat and pointer hold.
module tb_incr_share_arb;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] data;
      logic        rdy;
      logic [3:0]  exp_ready;
      string       tag;
   } vec_t;

   typedef struct packed {
      logic [1:0] id;
      logic [3:0] data;
      logic       sat;
   } rsp_t;

   logic        clock;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_data;
   logic        rsp_ready;
`ifdef INCR_SHARE_ARB_SAT_EN
   logic        rsp_sat;
`endif

   int   total;
   int   bad;
   bit   m_valid;
   rsp_t sb[$];
   vec_t vecs[$];

   incr_share_arb #(
      .NREQ  (4),
      .WIDTH (4)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
`ifdef INCR_SHARE_ARB_SAT_EN
      .rsp_sat   (rsp_sat),
`endif
      .rsp_ready (rsp_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   function automatic rsp_t model(input logic [1:0] id,
                                  input logic [3:0] d);
      rsp_t r;
      r.id = id;
`ifdef INCR_SHARE_ARB_SAT_EN
      r.sat  = (d == 4'hF);
      r.data = r.sat ? 4'hF : 4'(d + 4'd1);
`else
      r.sat  = 1'b0;
      r.data = 4'(d + 4'd1);
`endif
      return r;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, ".rsp_id"}, 32'(rsp_id), 32'd0);
      chk({tag, ".rsp_data"}, 32'(rsp_data), 32'd0);
      chk({tag, ".req_ready"}, 32'(req_ready), 32'd0);
`ifdef INCR_SHARE_ARB_SAT_EN
      chk({tag, ".rsp_sat"}, 32'(rsp_sat), 32'd0);
`endif
   endtask

   task automatic cycle(input vec_t v);
      rsp_t e;
      logic [3:0] opv;
      logic [1:0] gi;
      req_valid = v.valid;
      req_data  = v.data;
      rsp_ready = v.rdy;
      #1;
      chk({v.tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
         if (sb.size() == 0) begin
            chk({v.tag, ".sb_empty"}, 32'd1, 32'd0);
         end else begin
            e = sb[0];
            chk({v.tag, ".rsp_id"}, 32'(rsp_id), 32'(e.id));
            chk({v.tag, ".rsp_data"}, 32'(rsp_data), 32'(e.data));
`ifdef INCR_SHARE_ARB_SAT_EN
            chk({v.tag, ".rsp_sat"}, 32'(rsp_sat), 32'(e.sat));
`endif
            if (v.rdy) begin
               void'(sb.pop_front());
            end
         end
      end
      chk({v.tag, ".req_ready"}, 32'(req_ready), 32'(v.exp_ready));
      if (v.exp_ready != 4'd0) begin
         gi  = 2'd0;
         opv = 4'd0;
         for (int i = 0; i < 4; i++) begin
            if (v.exp_ready[i]) begin
               gi  = 2'(i);
               opv = 4'(v.data >> (4 * i));
            end
         end
         sb.push_back(model(gi, opv));
         m_valid = 1'b1;
      end else if (v.rdy) begin
         m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic add(input logic [3:0] va, input logic [15:0] d,
                      input logic r, input logic [3:0] er, input string t);
      vec_t v;
      v.valid     = va;
      v.data      = d;
      v.rdy       = r;
      v.exp_ready = er;
      v.tag       = t;
      vecs.push_back(v);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      m_valid = 1'b0;

      add(4'b0100, 16'h0300, 1'b1, 4'b0100, "single");
      add(4'b0000, 16'h0000, 1'b1, 4'b0000, "single_ret");
      add(4'b1000, 16'h7000, 1'b1, 4'b1000, "only3");
      add(4'b1111, 16'h4321, 1'b1, 4'b0001, "fair0");
      add(4'b1111, 16'h4321, 1'b1, 4'b0010, "fair1");
      add(4'b1111, 16'h4321, 1'b1, 4'b0100, "fair2");
      add(4'b1111, 16'h4321, 1'b1, 4'b1000, "fair3");
      add(4'b1111, 16'h4321, 1'b1, 4'b0001, "fair4");
      add(4'b1111, 16'h4321, 1'b1, 4'b0010, "fair5");
      add(4'b1111, 16'h4321, 1'b1, 4'b0100, "fair6");
      add(4'b1111, 16'h4321, 1'b1, 4'b1000, "fair7");
      add(4'b1000, 16'h7005, 1'b1, 4'b1000, "hold3");
      add(4'b1001, 16'h7005, 1'b1, 4'b0001, "hold03");
      add(4'b0010, 16'h00A0, 1'b0, 4'b0000, "stall0");
      add(4'b0010, 16'h00A0, 1'b0, 4'b0000, "stall1");
      add(4'b0010, 16'h00A0, 1'b0, 4'b0000, "stall2");
      add(4'b0010, 16'h00A0, 1'b1, 4'b0010, "swap");
      add(4'b0000, 16'h0000, 1'b1, 4'b0000, "swap_ret");
      add(4'b0001, 16'h000F, 1'b1, 4'b0001, "wrap");
      add(4'b0000, 16'h0000, 1'b1, 4'b0000, "wrap_ret");
      add(4'b0010, 16'h0020, 1'b1, 4'b0010, "drop_ld");
      add(4'b0100, 16'h0300, 1'b0, 4'b0000, "drop_stall");
      add(4'b0000, 16'h0000, 1'b1, 4'b0000, "drop_ret");
      add(4'b0101, 16'h0302, 1'b1, 4'b0100, "drop_keep");
      add(4'b1111, 16'h4321, 1'b1, 4'b1000, "pre_rst");

      reset_n   = 1'b0;
      req_valid = 4'hF;
      req_data  = 16'h4321;
      rsp_ready = 1'b1;
      #2;
      chk_zero("rst");
      @(posedge clock);
      req_valid = 4'h0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      for (int n = 0; n < vecs.size(); n++) begin
         cycle(vecs[n]);
      end

      req_valid = 4'hF;
      #2;
      reset_n = 1'b0;
      #1;
      chk_zero("mid_rst");
      req_valid = 4'h0;
      sb.delete();
      m_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      vecs.delete();
      add(4'b1111, 16'h4321, 1'b1, 4'b0001, "post_rst");
      add(4'b0000, 16'h0000, 1'b1, 4'b0000, "post_ret");
      add(4'b0000, 16'h0000, 1'b1, 4'b0000, "idle");
      for (int n = 0; n < vecs.size(); n++) begin
         cycle(vecs[n]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
